// File: rtl/psola_frame_sequencer_pkg.sv
// rtl/psola_frame_sequencer_pkg.sv - shared types, widths and helpers for the PSOLA frame sequencer
package psola_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

    localparam int ACC_WIDTH    = 32;
    localparam int SAMPLE_WIDTH = 16;
    localparam int TAU_WIDTH    = 11;
    localparam int LEN_WIDTH    = 12;
    localparam int DEF_TAU_MIN  = 20;
    localparam int DEF_TAU_MAX  = 1023;

    // Window lengths beyond the accumulation buffer depth are cut to the depth.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len, input int limit);
        if (int'(len) > limit)
            return LEN_WIDTH'(limit);
        return len;
    endfunction

endpackage

// File: rtl/psola_frame_sequencer_if.sv
// rtl/psola_frame_sequencer_if.sv - resynthesised audio sample stream
interface psola_frame_sequencer_if;
    import psola_frame_sequencer_pkg::*;

    logic [SAMPLE_WIDTH-1:0] tdata;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/psola_frame_sequencer_scale_saturate.sv
// rtl/psola_frame_sequencer_scale_saturate.sv - arithmetic shift and clamp of an accumulator word to sample width
module psola_frame_sequencer_scale_saturate
    import psola_frame_sequencer_pkg::*;
#(
    parameter int IN_WIDTH  = ACC_WIDTH,
    parameter int OUT_WIDTH = SAMPLE_WIDTH,
    parameter int SHIFT     = 10
) (
    input  logic [IN_WIDTH-1:0]  acc,
    output logic [OUT_WIDTH-1:0] sample
);

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH-1:0] shifted;

    // scale down, then pin anything outside the signed output range to the rail
    always_comb begin
        shifted = $signed(acc) >>> SHIFT;
        if (shifted > SAT_MAX)
            sample = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sample = SAT_MIN[OUT_WIDTH-1:0];
        else
            sample = shifted[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/psola_frame_sequencer.sv
// rtl/psola_frame_sequencer.sv - per-frame clear/launch/drain controller for the PSOLA accumulation buffer
module psola_frame_sequencer
    import psola_frame_sequencer_pkg::*;
#(
    parameter int MAX_EXTENDED   = 2200,
    parameter int ADDR_BITS      = $clog2(MAX_EXTENDED),
    parameter int TAU_MIN        = DEF_TAU_MIN,
    parameter int TAU_MAX        = DEF_TAU_MAX,
    parameter int SCALE_SHIFT    = 10,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   frame_valid_in,
    input  logic [TAU_WIDTH-1:0]   tau_in,
    output logic                   busy_out,
    output logic                   psola_tau_valid_out,
    output logic [TAU_WIDTH-1:0]   psola_tau_out,
    input  logic [LEN_WIDTH-1:0]   psola_window_len_in,
    input  logic                   psola_window_len_valid_in,
    input  logic [ADDR_BITS-1:0]   psola_write_addr_in,
    input  logic [ACC_WIDTH-1:0]   psola_write_val_in,
    input  logic                   psola_valid_write_in,
    output logic [ADDR_BITS-1:0]   acc_addr_out,
    output logic [ACC_WIDTH-1:0]   acc_wdata_out,
    output logic                   acc_we_out,
    input  logic [ACC_WIDTH-1:0]   acc_rdata_in,
    psola_frame_sequencer_if.master sample_if,
    output logic                   frame_done_out,
    output logic                   skipped_out,
    output logic                   timeout_out,
    output logic [7:0]             overrun_count_out
);

    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t              state, state_nxt;
    logic [ADDR_BITS-1:0]    clr_addr;
    logic [WD_BITS-1:0]      wd_cnt;
    logic [LEN_WIDTH-1:0]    win_len;
    logic [LEN_WIDTH-1:0]    len_clamped;
    logic [LEN_WIDTH-1:0]    rd_idx;
    logic                    rd_issue;
    logic [1:0]              rd_pipe;
    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic [SAMPLE_WIDTH-1:0] sample_scaled;
    logic                    sample_valid_q;
    logic [TAU_WIDTH-1:0]    tau_q;
    logic                    skipped_q;
    logic [7:0]              overrun_q;
    logic                    tau_ok;
    logic                    hs;
    logic                    drain_last;
    logic                    take_frame;
    logic                    skip_frame;
    logic                    overrun_inc;

    assign tau_ok      = (tau_in >= TAU_WIDTH'(TAU_MIN)) && (tau_in <= TAU_WIDTH'(TAU_MAX));
    assign len_clamped = clamp_len(psola_window_len_in, MAX_EXTENDED);
    assign hs          = sample_valid_q && sample_if.tready;
    assign drain_last  = (win_len == '0) || (hs && (rd_idx == win_len - LEN_WIDTH'(1)));

    assign busy_out            = (state != ST_IDLE);
    assign psola_tau_valid_out = (state == ST_START);
    assign psola_tau_out       = tau_q;
    assign sample_if.tdata     = sample_q;
    assign sample_if.tvalid    = sample_valid_q;
    assign skipped_out         = skipped_q;
    assign overrun_count_out   = overrun_q;

    psola_frame_sequencer_scale_saturate #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (SAMPLE_WIDTH),
        .SHIFT     (SCALE_SHIFT)
    ) u_scale (
        .acc    (acc_rdata_in),
        .sample (sample_scaled)
    );

    // state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next state, frame acceptance and single-cycle status pulses
    always_comb begin
        state_nxt      = state;
        frame_done_out = 1'b0;
        timeout_out    = 1'b0;
        take_frame     = 1'b0;
        skip_frame     = 1'b0;
        overrun_inc    = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_CLEAR: if (clr_addr == ADDR_BITS'(MAX_EXTENDED - 1)) state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (psola_window_len_valid_in) begin
                    state_nxt = ST_DRAIN;
                end else if (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                    timeout_out = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    frame_done_out = 1'b1;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // the final drain cycle behaves as idle so a back-to-back frame is not lost
        if (frame_valid_in) begin
            if (state == ST_IDLE || frame_done_out) begin
                if (tau_ok) begin
                    take_frame = 1'b1;
                    state_nxt  = ST_CLEAR;
                end else begin
                    skip_frame = 1'b1;
                end
            end else begin
                overrun_inc = 1'b1;
            end
        end
    end

    // port B owner follows the registered state; psola only reaches the buffer while running
    always_comb begin
        acc_addr_out  = '0;
        acc_wdata_out = '0;
        acc_we_out    = 1'b0;
        case (state)
            ST_CLEAR: begin
                acc_addr_out = clr_addr;
                acc_we_out   = 1'b1;
            end
            ST_RUN: begin
                acc_addr_out  = psola_write_addr_in;
                acc_wdata_out = psola_write_val_in;
                acc_we_out    = psola_valid_write_in;
            end
            ST_DRAIN: acc_addr_out = ADDR_BITS'(rd_idx);
            default: acc_we_out = 1'b0;
        endcase
    end

    // frame bookkeeping: tau latch, clear sweep, watchdog, length latch, overrun tally
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tau_q     <= '0;
            skipped_q <= 1'b0;
            overrun_q <= '0;
            clr_addr  <= '0;
            wd_cnt    <= '0;
            win_len   <= '0;
        end else begin
            skipped_q <= skip_frame;
            if (overrun_inc && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
            if (take_frame)
                tau_q <= tau_in;
            clr_addr <= (state == ST_CLEAR) ? clr_addr + ADDR_BITS'(1) : '0;
            wd_cnt   <= (state == ST_RUN) ? wd_cnt + WD_BITS'(1) : '0;
            if (state == ST_RUN && psola_window_len_valid_in)
                win_len <= len_clamped;
        end
    end

    // drain: one read in flight, data lands two cycles after its address, held until accepted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_idx         <= '0;
            rd_issue       <= 1'b0;
            rd_pipe        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            rd_issue <= (state == ST_RUN && psola_window_len_valid_in && len_clamped != '0) ||
                        (state == ST_DRAIN && hs && !drain_last);
            rd_pipe  <= {rd_pipe[0], rd_issue && (state == ST_DRAIN)};
            if (state != ST_DRAIN)
                rd_idx <= '0;
            else if (hs && !drain_last)
                rd_idx <= rd_idx + LEN_WIDTH'(1);
            if (state == ST_DRAIN && rd_pipe[1]) begin
                sample_q       <= sample_scaled;
                sample_valid_q <= 1'b1;
            end else if (hs || state != ST_DRAIN) begin
                sample_valid_q <= 1'b0;
            end
        end
    end

endmodule
